mul_issue_ctrl: RTL and testbench
=================================

// Module: mul_issue_ctrl
// PURPOSE
//  Sequencer between the CPU execute stage and the 32x32 unsigned iterative multiplier (shift_add_mul).
//  Accepts MUL/MULH/MULHSU/MULHU requests and converts signed operands to magnitudes.
//  Pulses the multiplier start, waits for its ready, then sign-corrects and selects the result word.
//  Holds the last product so a MULH/MUL pair on the same operands costs one multiply.
// PARAMETERS
//  XLEN    32  operand/result width (multiplier is fixed 32x32->64; only 32 supported)
//  FUSE_EN 1   1: enable last-product reuse; 0: every request issues a multiply
// PORTS
//  clk         in  1     clock
//  rst_n       in  1     asynchronous, active-low reset
//  flush       in  1     abort current op, invalidate reuse entry
//  req_valid   in  1     request present
//  req_ready   out 1     high only in IDLE; request accepted when req_valid&&req_ready
//  req_op      in  2     00 MUL(low), 01 MULH(ss), 10 MULHSU(su), 11 MULHU(uu)
//  req_a       in  32    rs1 operand
//  req_b       in  32    rs2 operand
//  resp_valid  out 1     one-cycle pulse, resp_data valid
//  resp_data   out 32    result word
//  busy        out 1     = !req_ready; pipeline stall
//  mul_start   out 1     one-cycle start to multiplier
//  mul_a       out 32    magnitude of A (registered, stable ISSUE..FIX)
//  mul_b       out 32    magnitude of B
//  mul_product in  64    unsigned product from multiplier
//  mul_ready   in  1     multiplier done (sticky until next start)
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; busy,resp_valid,mul_start=0; resp_data,mul_a,mul_b=0; reuse entry invalid.
//  FSM IDLE->ISSUE->WAIT->FIX->IDLE.
//   IDLE: on accept, latch op/a/b. On reuse hit, go directly to FIX with no mul_start.
//         On miss, compute magnitudes and go to ISSUE.
//   ISSUE: mul_start=1 for exactly one cycle, then WAIT.
//   WAIT: mul_ready is ignored in the first WAIT cycle (the start edge clears it).
//         Thereafter mul_ready=1 registers mul_product and goes to FIX.
//   FIX: produce the signed 64-bit product P: negate when neg=1.
//        neg = a[31]^b[31] for ss; a[31] for su; 0 for uu and MUL.
//        Select P[31:0] for MUL, else P[63:32].
//        Register resp_data, pulse resp_valid the next cycle in IDLE; update the reuse entry.
//  Timing: resp_valid appears 2 cycles after mul_ready is sampled high. Miss latency from accept is about 36 cycles.
//   Reuse hit: resp_valid 2 cycles after accept.
//  Magnitudes: abs(x) = x[31] ? -x : x for signed operands. abs(0x80000000) = 0x80000000 as unsigned. No overflow is special-cased.
//  Reuse entry: {valid, a, b, mode, P}; mode = ss/su/uu.
//   MUL hits on any stored mode with equal a,b, since the low word does not depend on signedness.
//   MULH* hits only when the mode matches.
//  flush: any state -> IDLE next cycle. No resp_valid; reuse entry invalidated; mul_start never issued after flush.
//   A multiplier still running is harmless; the next start restarts it.
//  flush and req_valid in the same cycle: flush wins, request not accepted.
//  resp_valid and a new accept may occur in the same IDLE cycle.
//  A response is never delayed by the next request.
//  req_* changes while busy are ignored.
// STRUCTURE
//  Package mul_pkg: op encodings (MUL_OP_*), mode encodings (MODE_SS/SU/UU), and the FSM state typedef.
//  Sub-module mul_sign_fix (comb): abs of the operands and the 64-bit conditional negate.
//  Sub-module mul_sign_fix is instantiated once for operands and once for the product.
// TESTING
//  Instantiate with the real shift_add_mul.
//  1 MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> resp 0xFFFFFFFE; mul_start asserted exactly once.
//  2 MULH a=-2 b=3 -> resp 0xFFFFFFFF; then MUL with the same operands -> resp 0xFFFFFFFA.
//    The MUL hits: no mul_start, and resp_valid 2 cycles after accept.
//  3 MULHSU a=0x80000000 b=2 -> resp 0xFFFFFFFF; MULH a=b=0x80000000 -> resp 0x40000000.
//  4 flush asserted in WAIT -> no resp_valid, req_ready=1 next cycle.
//    A following MUL with equal operands must miss and issue a start.
//  5 Reset mid-WAIT -> all outputs at reset values. A stale mul_ready=1 with no start issued causes no response.
//  6 Back-to-back: req_valid held with 8 random ops/operands -> each result matches the reference model.
//    Rerun with FUSE_EN=0: no reuse hits.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared encodings for the multiply issue controller:
// request opcodes, signedness modes and the FSM state type.
package mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        MODE_SS = 2'b00,
        MODE_SU = 2'b01,
        MODE_UU = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_FIX   = 2'b11
    } state_e;

    // MUL only needs the low word, which is the same for any signedness
    function automatic mode_e op_mode(input logic [1:0] op);
        mode_e m;
        m = MODE_UU;
        if (op == MUL_OP_MULH)
            m = MODE_SS;
        else if (op == MUL_OP_MULHSU)
            m = MODE_SU;
        return m;
    endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Per-lane conditional two's-complement negate.
// Used for operand magnitudes and for the final product sign.
module mul_sign_fix #(
    parameter int N = 1,
    parameter int W = 32
) (
    input  logic [N-1:0][W-1:0] x,
    input  logic [N-1:0]        neg,
    output logic [N-1:0][W-1:0] y
);

    // negate each lane whose flag is set
    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++)
            y[i] = neg[i] ? -x[i] : x[i];
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Sequencer between execute and the iterative 32x32 multiplier.
// Handles signedness, result word select and last-product reuse.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit FUSE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [XLEN-1:0]   req_a,
    input  logic [XLEN-1:0]   req_b,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_data,
    output logic              busy,
    output logic              mul_start,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    input  logic [2*XLEN-1:0] mul_product,
    input  logic              mul_ready
);

    state_e              state;
    logic [1:0]          op_r;
    logic [XLEN-1:0]     a_r;
    logic [XLEN-1:0]     b_r;
    mode_e               mode_r;
    logic                neg_r;
    logic [2*XLEN-1:0]   prod_r;
    logic                wait_first;

    logic                ent_v;
    logic [XLEN-1:0]     ent_a;
    logic [XLEN-1:0]     ent_b;
    mode_e               ent_m;
    logic [2*XLEN-1:0]   ent_p;

    mode_e               req_mode;
    logic                neg_req;
    logic [1:0]          neg_in;
    logic                hit;
    logic                accept;
    logic [1:0][XLEN-1:0] mag;
    logic [2*XLEN-1:0]   p_fix;

    assign req_ready = (state == S_IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid && req_ready && !flush;
    assign req_mode  = op_mode(req_op);

    // operand sign flags and product sign for the incoming request
    always_comb begin
        neg_req   = 1'b0;
        neg_in    = 2'b00;
        unique case (req_mode)
            MODE_SS: begin
                neg_req   = req_a[XLEN-1] ^ req_b[XLEN-1];
                neg_in[0] = req_a[XLEN-1];
                neg_in[1] = req_b[XLEN-1];
            end
            MODE_SU: begin
                neg_req   = req_a[XLEN-1];
                neg_in[0] = req_a[XLEN-1];
            end
            default: ;
        endcase
    end

    // reuse lookup: MUL matches any mode, MULH* needs the same mode
    always_comb begin
        hit = FUSE_EN && ent_v &&
              (req_a == ent_a) && (req_b == ent_b) &&
              ((req_op == MUL_OP_MUL) || (req_mode == ent_m));
    end

    mul_sign_fix #(.N(2), .W(XLEN)) u_opnd_fix (
        .x   ({req_b, req_a}),
        .neg (neg_in),
        .y   (mag)
    );

    mul_sign_fix #(.N(1), .W(2*XLEN)) u_prod_fix (
        .x   (prod_r),
        .neg (neg_r),
        .y   (p_fix)
    );

    // issue FSM, result registers and reuse entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_r       <= MUL_OP_MUL;
            a_r        <= '0;
            b_r        <= '0;
            mode_r     <= MODE_UU;
            neg_r      <= 1'b0;
            prod_r     <= '0;
            wait_first <= 1'b0;
            ent_v      <= 1'b0;
            ent_a      <= '0;
            ent_b      <= '0;
            ent_m      <= MODE_UU;
            ent_p      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
        end else begin
            mul_start  <= 1'b0;
            resp_valid <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                ent_v <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (accept) begin
                            op_r <= req_op;
                            a_r  <= req_a;
                            b_r  <= req_b;
                            if (hit) begin
                                mode_r <= ent_m;
                                neg_r  <= 1'b0;
                                prod_r <= ent_p;
                                state  <= S_FIX;
                            end else begin
                                mode_r    <= req_mode;
                                neg_r     <= neg_req;
                                mul_a     <= mag[0];
                                mul_b     <= mag[1];
                                mul_start <= 1'b1;
                                state     <= S_ISSUE;
                            end
                        end
                    end
                    S_ISSUE: begin
                        wait_first <= 1'b1;
                        state      <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (wait_first) begin
                            wait_first <= 1'b0;
                        end else if (mul_ready) begin
                            prod_r <= mul_product;
                            state  <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        resp_data  <= (op_r == MUL_OP_MUL) ?
                                      p_fix[XLEN-1:0] :
                                      p_fix[2*XLEN-1:XLEN];
                        resp_valid <= 1'b1;
                        ent_v      <= FUSE_EN;
                        ent_a      <= a_r;
                        ent_b      <= b_r;
                        ent_m      <= mode_r;
                        ent_p      <= p_fix;
                        state      <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: fused and non-fused instances,
// each driving a behavioural 32-cycle multiplier.
module tb_mul_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        rv;
    int          sel;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        stale;

    logic        rv0, rv1, mr0_in;
    logic        rdy[2], rsp_v[2], bsy[2], ms[2], mr[2];
    logic [31:0] rsp_d[2], ma[2], mb[2];
    logic [63:0] mp[2];

    int          cnt[2];
    logic [31:0] la[2], lb[2];
    int          starts[2] = '{0, 0};

    int          ncmp = 0;
    int          nfail = 0;

    bit          ev[2];
    logic [31:0] ea[2], eb[2];
    int          em[2];

    assign rv0    = rv && (sel == 0);
    assign rv1    = rv && (sel == 1);
    assign mr0_in = mr[0] | stale;

    always #5 clk = ~clk;

    mul_issue_ctrl #(.XLEN(32), .FUSE_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(rv0), .req_ready(rdy[0]), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(rsp_v[0]), .resp_data(rsp_d[0]), .busy(bsy[0]),
        .mul_start(ms[0]), .mul_a(ma[0]), .mul_b(mb[0]),
        .mul_product(mp[0]), .mul_ready(mr0_in)
    );

    mul_issue_ctrl #(.XLEN(32), .FUSE_EN(1'b0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(rv1), .req_ready(rdy[1]), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(rsp_v[1]), .resp_data(rsp_d[1]), .busy(bsy[1]),
        .mul_start(ms[1]), .mul_a(ma[1]), .mul_b(mb[1]),
        .mul_product(mp[1]), .mul_ready(mr[1])
    );

    // behavioural multipliers: ready sticky until next start
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mr[i]  <= 1'b0;
                cnt[i] <= 0;
                mp[i]  <= '0;
                la[i]  <= '0;
                lb[i]  <= '0;
            end else if (ms[i]) begin
                mr[i]  <= 1'b0;
                cnt[i] <= 32;
                la[i]  <= ma[i];
                lb[i]  <= mb[i];
            end else if (cnt[i] != 0) begin
                cnt[i] <= cnt[i] - 1;
                if (cnt[i] == 1) begin
                    mr[i] <= 1'b1;
                    mp[i] <= {32'b0, la[i]} * {32'b0, lb[i]};
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (ms[i]) starts[i] <= starts[i] + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 = signed x signed, 1 = signed x unsigned, 2 = unsigned
    function automatic int mode_of(input logic [1:0] op);
        if (op == 2'd1) return 0;
        if (op == 2'd2) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] ref_res(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ua, ub, p;
        logic [63:0] pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            2'd1:    p = sa * sb;
            2'd2:    p = sa * ub;
            default: p = ua * ub;
        endcase
        pv = p;
        return (op == 2'd0) ? pv[31:0] : pv[63:32];
    endfunction

    function automatic bit predict_hit(input int s, input logic [1:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        return (s == 0) && ev[s] && (ea[s] == a) && (eb[s] == b) &&
               ((op == 2'd0) || (em[s] == mode_of(op)));
    endfunction

    task automatic note(input int s, input bit h, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        if (!h) begin
            ev[s] = 1'b1;
            ea[s] = a;
            eb[s] = b;
            em[s] = mode_of(op);
        end
    endtask

    task automatic do_op(input int s, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        bit          h;
        int          st0;
        int          n;
        logic [31:0] e;
        h = predict_hit(s, op, a, b);
        e = ref_res(op, a, b);
        @(negedge clk);
        chk("ready_before", rdy[s], 1);
        sel = s; req_op = op; req_a = a; req_b = b; rv = 1'b1;
        st0 = starts[s];
        @(negedge clk);
        rv = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_v[s] && n < 100);
        chk("resp_valid", rsp_v[s], 1);
        chk("resp_data", rsp_d[s], e);
        chk("start_count", starts[s] - st0, h ? 0 : 1);
        if (h) chk("hit_latency", n + 1, 2);
        @(negedge clk);
        chk("resp_pulse", rsp_v[s], 0);
        note(s, h, op, a, b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ev[0] = 1'b0;
        ev[1] = 1'b0;
    endtask

    initial begin
        int          st0, nresp, pushed, got, cyc, misses;
        logic [31:0] exp_q[$];
        logic [31:0] pa[3];
        logic [31:0] pb[3];
        logic [31:0] a, b;
        logic [1:0]  op;
        bit          h;

        pa = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0007};
        pb = '{32'h0000_0003, 32'hFFFF_FFFE, 32'h8000_0000};
        flush = 1'b0; rv = 1'b0; sel = 0; stale = 1'b0;
        req_op = 2'd0; req_a = '0; req_b = '0;
        do_reset();

        @(negedge clk);
        chk("rst_ready", rdy[0], 1);
        chk("rst_busy", bsy[0], 0);
        chk("rst_resp_valid", rsp_v[0], 0);
        chk("rst_start", ms[0], 0);
        chk("rst_resp_data", rsp_d[0], 0);
        chk("rst_mul_a", ma[0], 0);
        chk("rst_mul_b", mb[0], 0);

        do_op(0, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(0, 2'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        do_op(0, 2'd0, 32'hFFFF_FFFE, 32'h0000_0003);
        do_op(0, 2'd2, 32'h8000_0000, 32'h0000_0002);
        do_op(0, 2'd1, 32'h8000_0000, 32'h8000_0000);

        // flush in WAIT; the MUL afterwards would have hit the UU entry
        do_op(0, 2'd3, 32'd5, 32'd7);
        @(negedge clk);
        sel = 0; req_op = 2'd1; req_a = 32'd5; req_b = 32'd7; rv = 1'b1;
        @(negedge clk);
        rv = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush_busy_before", bsy[0], 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        ev[0] = 1'b0;
        chk("flush_ready", rdy[0], 1);
        nresp = 0;
        st0 = starts[0];
        repeat (50) begin
            @(negedge clk);
            if (rsp_v[0]) nresp++;
        end
        chk("flush_no_resp", nresp, 0);
        chk("flush_no_start", starts[0] - st0, 0);
        do_op(0, 2'd0, 32'd5, 32'd7);

        // reset while waiting, then a stale ready with no start
        @(negedge clk);
        sel = 0; req_op = 2'd3; req_a = 32'h1234_5678; req_b = 32'h9; rv = 1'b1;
        @(negedge clk);
        rv = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", rdy[0], 1);
        chk("midrst_busy", bsy[0], 0);
        chk("midrst_resp_valid", rsp_v[0], 0);
        chk("midrst_start", ms[0], 0);
        chk("midrst_resp_data", rsp_d[0], 0);
        chk("midrst_mul_a", ma[0], 0);
        chk("midrst_mul_b", mb[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        ev[0] = 1'b0;
        ev[1] = 1'b0;
        stale = 1'b1;
        nresp = 0;
        st0 = starts[0];
        repeat (40) begin
            @(negedge clk);
            if (rsp_v[0]) nresp++;
        end
        stale = 1'b0;
        chk("stale_no_resp", nresp, 0);
        chk("stale_no_start", starts[0] - st0, 0);
        do_op(0, 2'd1, 32'hFFFF_FFF9, 32'h0000_0011);

        // back-to-back random ops, req_valid held between requests
        for (int s = 0; s < 2; s++) begin
            exp_q.delete();
            pushed = 0; got = 0; cyc = 0; misses = 0;
            a = '0; b = '0;
            sel = s;
            st0 = starts[s];
            while ((pushed < 8 || got < 8) && cyc < 2000) begin
                @(negedge clk);
                cyc++;
                if (rsp_v[s]) begin
                    if (exp_q.size() != 0) begin
                        chk("b2b_data", rsp_d[s], exp_q.pop_front());
                    end else begin
                        chk("b2b_extra_resp", rsp_v[s], 0);
                    end
                    got++;
                end
                if (rdy[s] && pushed < 8) begin
                    op = 2'($urandom_range(0, 3));
                    if ((pushed % 2) == 0) begin
                        a = pa[$urandom_range(0, 2)];
                        b = pb[$urandom_range(0, 2)];
                    end
                    h = predict_hit(s, op, a, b);
                    if (!h) misses++;
                    exp_q.push_back(ref_res(op, a, b));
                    note(s, h, op, a, b);
                    req_op = op; req_a = a; req_b = b; rv = 1'b1;
                    pushed++;
                end else if (pushed == 8) begin
                    rv = 1'b0;
                end
            end
            rv = 1'b0;
            chk("b2b_resp_count", got, 8);
            chk("b2b_start_count", starts[s] - st0, misses);
        end

        // no-reuse instance: MULH then MUL on equal operands both multiply
        do_op(1, 2'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        do_op(1, 2'd0, 32'hFFFF_FFFE, 32'h0000_0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
